// File: rtl/ping_pong_merge_pkg.sv
// Shared definitions for the ping-pong splitter/merger pair.
package ping_pong_merge_pkg;

  typedef enum logic {
    SRC1 = 1'b0,
    SRC2 = 1'b1
  } src_e;

  localparam int unsigned GRP_W = 24;

endpackage

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head is visible the cycle after the write.
module axis_sync_fifo #(
  parameter int unsigned DW         = 128,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ping_pong_merge.sv
// Rebuilds one ordered AXI-Stream from the two splitter outputs, group by group.
module ping_pong_merge
  import ping_pong_merge_pkg::*;
#(
  parameter int unsigned DW         = 128,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [15:0]   PACKET_SIZE,
  input  logic [7:0]    PP_GROUP,
  input  logic [DW-1:0] axis_in1_tdata,
  input  logic          axis_in1_tvalid,
  output logic          axis_in1_tready,
  input  logic [DW-1:0] axis_in2_tdata,
  input  logic          axis_in2_tvalid,
  output logic          axis_in2_tready,
  output logic [DW-1:0] axis_out_tdata,
  output logic          axis_out_tvalid,
  input  logic          axis_out_tready,
  output logic          axis_out_tlast,
  output logic          overflow1,
  output logic          overflow2
);

  src_e             state;
  logic             rdy_en;
  logic [15:0]      pkt_len;
  logic [15:0]      pkt_cnt;
  logic [GRP_W-1:0] grp_len;
  logic [GRP_W-1:0] grp_cnt;

  logic [DW-1:0] head1, head2;
  logic          full1, full2, empty1, empty2;
  logic          cfg_ok, sel_empty, xfer;

  // Ready is held low until the first edge after reset, then tracks FIFO space.
  assign axis_in1_tready = rdy_en && !full1;
  assign axis_in2_tready = rdy_en && !full2;

  assign cfg_ok          = (pkt_len != '0) && (grp_len != '0);
  assign sel_empty       = (state == SRC1) ? empty1 : empty2;
  assign axis_out_tvalid = cfg_ok && !sel_empty;
  assign axis_out_tdata  = !axis_out_tvalid ? '0 : ((state == SRC1) ? head1 : head2);
  assign axis_out_tlast  = axis_out_tvalid && (pkt_cnt == pkt_len - 16'd1);
  assign xfer            = axis_out_tvalid && axis_out_tready;

  axis_sync_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (axis_in1_tvalid && axis_in1_tready),
    .wr_data (axis_in1_tdata),
    .rd_en   (xfer && (state == SRC1)),
    .rd_data (head1),
    .full    (full1),
    .empty   (empty1)
  );

  axis_sync_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo2 (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (axis_in2_tvalid && axis_in2_tready),
    .wr_data (axis_in2_tdata),
    .rd_en   (xfer && (state == SRC2)),
    .rd_data (head2),
    .full    (full2),
    .empty   (empty2)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= SRC1;
      rdy_en    <= 1'b0;
      pkt_len   <= '0;
      pkt_cnt   <= '0;
      grp_len   <= '0;
      grp_cnt   <= '0;
      overflow1 <= 1'b0;
      overflow2 <= 1'b0;
    end else begin
      rdy_en    <= 1'b1;
      overflow1 <= overflow1 | (axis_in1_tvalid && !axis_in1_tready);
      overflow2 <= overflow2 | (axis_in2_tvalid && !axis_in2_tready);
      if (xfer) begin
        pkt_cnt <= axis_out_tlast ? '0 : pkt_cnt + 16'd1;
        if (grp_cnt == grp_len - GRP_W'(1)) begin
          grp_cnt <= '0;
          state   <= (state == SRC1) ? SRC2 : SRC1;
        end else begin
          grp_cnt <= grp_cnt + GRP_W'(1);
        end
      end else if (grp_cnt == '0) begin
        // Config only moves at an idle group start so a group never changes length.
        pkt_len <= PACKET_SIZE;
        grp_len <= GRP_W'(PP_GROUP) * GRP_W'(PACKET_SIZE);
      end
    end
  end

endmodule

// File: tb/tb_ping_pong_merge.sv
// Randomised bench for ping_pong_merge against a queue-based reference model.
module tb_ping_pong_merge;

  localparam int unsigned DW    = 128;
  localparam int          DEPTH = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic [15:0]   PACKET_SIZE;
  logic [7:0]    PP_GROUP;
  logic [DW-1:0] in1_tdata, in2_tdata, out_tdata;
  logic          in1_tvalid, in1_tready, in2_tvalid, in2_tready;
  logic          out_tvalid, out_tready, out_tlast, ovf1, ovf2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] q1[$], q2[$];
  int  side, pkt_pos, grp_pos, m_pkt, m_grp;
  bit  m_rdy_en, m_ovf1, m_ovf2;
  logic [DW-1:0] obs_d[$];
  bit  obs_l[$];
  bit  prev_stall;
  logic [DW-1:0] prev_d;
  bit  prev_l;

  always #5 clk = ~clk;

  ping_pong_merge #(.DW(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .PACKET_SIZE     (PACKET_SIZE),
    .PP_GROUP        (PP_GROUP),
    .axis_in1_tdata  (in1_tdata),
    .axis_in1_tvalid (in1_tvalid),
    .axis_in1_tready (in1_tready),
    .axis_in2_tdata  (in2_tdata),
    .axis_in2_tvalid (in2_tvalid),
    .axis_in2_tready (in2_tready),
    .axis_out_tdata  (out_tdata),
    .axis_out_tvalid (out_tvalid),
    .axis_out_tready (out_tready),
    .axis_out_tlast  (out_tlast),
    .overflow1       (ovf1),
    .overflow2       (ovf2)
  );

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model_reset();
    q1.delete(); q2.delete();
    side = 0; pkt_pos = 0; grp_pos = 0; m_pkt = 0; m_grp = 0;
    m_rdy_en = 0; m_ovf1 = 0; m_ovf2 = 0; prev_stall = 0;
  endfunction

  // Called just after a negedge: compare, then advance model across the posedge.
  task automatic cycle();
    bit exp_v, exp_l, r1, r2, xfer;
    logic [DW-1:0] exp_d;
    exp_v = (m_pkt != 0) && (m_grp != 0) && ((side == 0) ? q1.size() != 0 : q2.size() != 0);
    r1 = m_rdy_en && (q1.size() < DEPTH);
    r2 = m_rdy_en && (q2.size() < DEPTH);
    checks += 5;
    if (out_tvalid !== exp_v) begin errors++; $display("FAIL tvalid got %b exp %b t=%0t", out_tvalid, exp_v, $time); end
    if (in1_tready !== r1) begin errors++; $display("FAIL in1_tready got %b exp %b t=%0t", in1_tready, r1, $time); end
    if (in2_tready !== r2) begin errors++; $display("FAIL in2_tready got %b exp %b t=%0t", in2_tready, r2, $time); end
    if (ovf1 !== m_ovf1) begin errors++; $display("FAIL overflow1 got %b exp %b t=%0t", ovf1, m_ovf1, $time); end
    if (ovf2 !== m_ovf2) begin errors++; $display("FAIL overflow2 got %b exp %b t=%0t", ovf2, m_ovf2, $time); end
    if (exp_v) begin
      exp_d = (side == 0) ? q1[0] : q2[0];
      exp_l = (pkt_pos == m_pkt - 1);
      checks += 2;
      if (out_tdata !== exp_d) begin errors++; $display("FAIL tdata got %h exp %h t=%0t", out_tdata, exp_d, $time); end
      if (out_tlast !== exp_l) begin errors++; $display("FAIL tlast got %b exp %b t=%0t", out_tlast, exp_l, $time); end
    end
    if (prev_stall) begin
      checks++;
      if (out_tvalid !== 1'b1 || out_tdata !== prev_d || out_tlast !== prev_l) begin
        errors++; $display("FAIL stall_stable got v=%b d=%h l=%b exp d=%h l=%b", out_tvalid, out_tdata, out_tlast, prev_d, prev_l);
      end
    end
    prev_stall = (out_tvalid === 1'b1) && !out_tready;
    prev_d = out_tdata; prev_l = out_tlast;
    if (out_tvalid === 1'b1 && out_tready) begin obs_d.push_back(out_tdata); obs_l.push_back(out_tlast); end
    @(posedge clk);
    xfer = exp_v && out_tready;
    if (in1_tvalid) begin if (r1) q1.push_back(in1_tdata); else m_ovf1 = 1; end
    if (in2_tvalid) begin if (r2) q2.push_back(in2_tdata); else m_ovf2 = 1; end
    if (xfer) begin
      if (side == 0) void'(q1.pop_front()); else void'(q2.pop_front());
      pkt_pos = (pkt_pos == m_pkt - 1) ? 0 : pkt_pos + 1;
      if (grp_pos == m_grp - 1) begin grp_pos = 0; side = 1 - side; end
      else grp_pos++;
    end else if (grp_pos == 0) begin
      m_pkt = int'(PACKET_SIZE);
      m_grp = int'(PP_GROUP) * int'(PACKET_SIZE);
    end
    m_rdy_en = 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in1_tvalid = 0; in2_tvalid = 0;
    resetn = 0;
    #1;
    checks += 7;
    if (out_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b exp 0", out_tvalid); end
    if (out_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b exp 0", out_tlast); end
    if (out_tdata !== '0) begin errors++; $display("FAIL rst_tdata got %h exp 0", out_tdata); end
    if (in1_tready !== 1'b0) begin errors++; $display("FAIL rst_in1_tready got %b exp 0", in1_tready); end
    if (in2_tready !== 1'b0) begin errors++; $display("FAIL rst_in2_tready got %b exp 0", in2_tready); end
    if (ovf1 !== 1'b0) begin errors++; $display("FAIL rst_overflow1 got %b exp 0", ovf1); end
    if (ovf2 !== 1'b0) begin errors++; $display("FAIL rst_overflow2 got %b exp 0", ovf2); end
    model_reset();
    #1 resetn = 1;
  endtask

  task automatic push1(input logic [DW-1:0] d);
    in1_tvalid = 1; in1_tdata = d; cycle(); in1_tvalid = 0;
  endtask

  task automatic push2(input logic [DW-1:0] d);
    in2_tvalid = 1; in2_tdata = d; cycle(); in2_tvalid = 0;
  endtask

  task automatic drain(input int n, input int budget);
    int c = 0;
    while (obs_d.size() < n && c < budget) begin cycle(); c++; end
    checks++;
    if (obs_d.size() != n) begin errors++; $display("FAIL drain_count got %0d exp %0d", obs_d.size(), n); end
  endtask

  task automatic test_reset();
    PACKET_SIZE = 4; PP_GROUP = 2;
    @(negedge clk);
    do_reset();
    repeat (3) cycle();
  endtask

  task automatic test_basic();
    PACKET_SIZE = 4; PP_GROUP = 2; out_tready = 1;
    do_reset(); cycle();
    obs_d.delete(); obs_l.delete();
    for (int i = 0; i < 8; i++) push1(DW'(i));
    for (int i = 8; i < 16; i++) push2(DW'(i));
    drain(16, 50);
    for (int k = 0; k < 16 && k < obs_d.size(); k++) begin
      checks += 2;
      if (obs_d[k] !== DW'(k)) begin errors++; $display("FAIL basic_seq[%0d] got %h exp %0d", k, obs_d[k], k); end
      if (obs_l[k] !== (k % 4 == 3)) begin errors++; $display("FAIL basic_last[%0d] got %b exp %b", k, obs_l[k], (k % 4 == 3)); end
    end
  endtask

  task automatic test_in2_first();
    PACKET_SIZE = 4; PP_GROUP = 2; out_tready = 1;
    do_reset(); cycle();
    obs_d.delete(); obs_l.delete();
    for (int i = 8; i < 16; i++) push2(DW'(i));
    repeat (4) cycle();
    checks++;
    if (obs_d.size() != 0) begin errors++; $display("FAIL in2_first_early got %0d beats exp 0", obs_d.size()); end
    for (int i = 0; i < 8; i++) push1(DW'(i));
    drain(16, 50);
    for (int k = 0; k < 16 && k < obs_d.size(); k++) begin
      checks++;
      if (obs_d[k] !== DW'(k)) begin errors++; $display("FAIL in2_first_seq[%0d] got %h exp %0d", k, obs_d[k], k); end
    end
  endtask

  task automatic test_overflow();
    PACKET_SIZE = 4; PP_GROUP = 4; out_tready = 0;
    do_reset(); cycle();
    obs_d.delete(); obs_l.delete();
    for (int i = 0; i < 20; i++) push1(DW'(100 + i));
    checks += 2;
    if (ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf1); end
    if (in1_tready !== 1'b0) begin errors++; $display("FAIL ovf_ready got %b exp 0", in1_tready); end
    out_tready = 1;
    drain(16, 40);
    for (int k = 0; k < 16 && k < obs_d.size(); k++) begin
      checks++;
      if (obs_d[k] !== DW'(100 + k)) begin errors++; $display("FAIL ovf_seq[%0d] got %h exp %0d", k, obs_d[k], 100 + k); end
    end
  endtask

  task automatic test_random();
    int s1 = 0, s2 = 0, c = 0;
    PACKET_SIZE = 5; PP_GROUP = 4; out_tready = 0;
    do_reset(); cycle();
    obs_d.delete(); obs_l.delete();
    while (obs_d.size() < 1000 && c < 20000) begin
      in1_tvalid = (s1 < 500) && ($urandom_range(3) != 0) && (q1.size() < DEPTH) && m_rdy_en;
      if (in1_tvalid) begin in1_tdata = rnd(); s1++; end
      in2_tvalid = (s2 < 500) && ($urandom_range(3) != 0) && (q2.size() < DEPTH) && m_rdy_en;
      if (in2_tvalid) begin in2_tdata = rnd(); s2++; end
      out_tready = 1'($urandom_range(1));
      cycle(); c++;
    end
    in1_tvalid = 0; in2_tvalid = 0;
    checks++;
    if (obs_d.size() != 1000) begin errors++; $display("FAIL random_count got %0d exp 1000", obs_d.size()); end
  endtask

  task automatic test_zero_cfg();
    PACKET_SIZE = 0; PP_GROUP = 2; out_tready = 1;
    do_reset(); cycle();
    obs_d.delete(); obs_l.delete();
    for (int i = 0; i < 4; i++) push1(DW'(200 + i));
    repeat (8) cycle();
    checks++;
    if (obs_d.size() != 0) begin errors++; $display("FAIL zero_cfg_out got %0d beats exp 0", obs_d.size()); end
    PACKET_SIZE = 2;
    drain(4, 10);
    for (int k = 0; k < 4 && k < obs_d.size(); k++) begin
      checks += 2;
      if (obs_d[k] !== DW'(200 + k)) begin errors++; $display("FAIL zero_cfg_seq[%0d] got %h exp %0d", k, obs_d[k], 200 + k); end
      if (obs_l[k] !== (k % 2 == 1)) begin errors++; $display("FAIL zero_cfg_last[%0d] got %b exp %b", k, obs_l[k], (k % 2 == 1)); end
    end
  endtask

  task automatic test_reset_mid();
    PACKET_SIZE = 4; PP_GROUP = 2; out_tready = 1;
    do_reset(); cycle();
    for (int i = 0; i < 5; i++) push1(DW'(300 + i));
    push2(DW'(400));
    do_reset();
    obs_d.delete(); obs_l.delete();
    for (int i = 0; i < 3; i++) push2(DW'(500 + i));
    for (int i = 0; i < 3; i++) push1(DW'(600 + i));
    drain(3, 10);
    for (int k = 0; k < 3 && k < obs_d.size(); k++) begin
      checks++;
      if (obs_d[k] !== DW'(600 + k)) begin errors++; $display("FAIL reset_mid_seq[%0d] got %h exp %0d", k, obs_d[k], 600 + k); end
    end
  endtask

  initial begin
    resetn = 0; in1_tvalid = 0; in2_tvalid = 0; out_tready = 0;
    in1_tdata = '0; in2_tdata = '0; PACKET_SIZE = 0; PP_GROUP = 0;
    model_reset();
    test_reset();
    test_basic();
    test_in2_first();
    test_overflow();
    test_random();
    test_zero_cfg();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
